// File: rtl/success_detector.sv
// Sokoban level-solved detector: scans the map RAM after each move.
// Optional `SUCCESS_LATCH_EN keeps success high until rst or level_clear.
module success_detector #(
    parameter int NUM_CELLS = 64,
    parameter int ADDR_W    = 6,
    parameter int CELL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    input  logic              level_clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [CELL_W-1:0] mem_data,
    output logic              success,
    output logic [ADDR_W:0]   loose_boxes,
    output logic              scan_busy,
    output logic              scan_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [CELL_W-1:0] CODE_BOX    = CELL_W'(2);
    localparam logic [CELL_W-1:0] CODE_PLACED = CELL_W'(4);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ADDR_W:0]   ONE         = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_vld_q, rd_vld_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              succ_q, succ_d;
    logic [ADDR_W:0]   lout_q, lout_d;
    logic [ADDR_W:0]   loose_q, loose_d;
    logic [ADDR_W:0]   placed_q, placed_d;
    logic              solved;

    assign solved = (loose_q == '0) && (placed_q != '0);

    // Next-state: scan sequencing, accumulation and result update
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_en_d  = rd_en_q;
        rd_vld_d = rd_en_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        succ_d   = succ_q;
        lout_d   = lout_q;
        loose_d  = loose_q;
        placed_d = placed_q;

        if (rd_vld_q) begin
            if (mem_data == CODE_BOX)    loose_d  = loose_q + ONE;
            if (mem_data == CODE_PLACED) placed_d = placed_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d  = ISSUE;
                    addr_d   = '0;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    loose_d  = '0;
                    placed_d = '0;
                end
            end
            ISSUE: begin
                if (scan_start) pend_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (scan_start) pend_d = 1'b1;
                state_d = FINISH;
            end
            FINISH: begin
                done_d = 1'b1;
                lout_d = loose_q;
`ifdef SUCCESS_LATCH_EN
                succ_d = succ_q | solved;
`else
                succ_d = solved;
`endif
                // a request arriving now still earns one more scan
                if (pend_q || scan_start) begin
                    state_d  = ISSUE;
                    pend_d   = 1'b0;
                    addr_d   = '0;
                    rd_en_d  = 1'b1;
                    loose_d  = '0;
                    placed_d = '0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (level_clear) begin
            state_d  = IDLE;
            addr_d   = '0;
            rd_en_d  = 1'b0;
            rd_vld_d = 1'b0;
            pend_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            succ_d   = 1'b0;
            lout_d   = '0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            succ_q   <= 1'b0;
            lout_q   <= '0;
            loose_q  <= '0;
            placed_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_en_q  <= rd_en_d;
            rd_vld_q <= rd_vld_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            succ_q   <= succ_d;
            lout_q   <= lout_d;
            loose_q  <= loose_d;
            placed_q <= placed_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign success     = succ_q;
    assign loose_boxes = lout_q;
    assign scan_busy   = busy_q;
    assign scan_done   = done_q;

endmodule
